// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial two's-complement adder/subtractor.
// A WIDTH-bit operation is processed DIGIT bits per clock through one reused
// ripple slice. Valid/ready handshakes sit on both the operand and the result
// side. Status flags are registered, and an accumulator can stand in for
// operand A to chain operations.
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             carry_out_r;
    logic             overflow_r;
    logic             zero_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic             accept_s;
    logic             last_s;
    logic             release_s;
    logic [DIGIT-1:0] a_sl_s;
    logic [DIGIT-1:0] b_sl_s;
    logic [DIGIT:0]   slice_s;
    logic [WIDTH-1:0] sum_next_s;
    logic             c_msb_s;

    // One ripple slice on the current digit, plus the merged result word.
    always_comb begin
        a_sl_s     = opa_r[int'(cnt_r) * DIGIT +: DIGIT];
        b_sl_s     = opb_r[int'(cnt_r) * DIGIT +: DIGIT];
        slice_s    = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{DIGIT{1'b0}}, carry_r};
        sum_next_s = sum_r;
        sum_next_s[int'(cnt_r) * DIGIT +: DIGIT] = slice_s[DIGIT-1:0];
        // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
        // This works for any DIGIT, including DIGIT = 1.
        c_msb_s    = opa_r[WIDTH-1] ^ opb_r[WIDTH-1] ^ sum_next_s[WIDTH-1];
    end

    // Handshake qualifiers and next-state selection.
    always_comb begin
        state_s   = state_r;
        accept_s  = (state_r == IDLE) && in_valid;
        last_s    = (state_r == RUN) && (cnt_r == LAST_CNT);
        release_s = (state_r == DONE) && out_ready;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register, with the handshake outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

    // Operand capture, serial digit processing, flag capture and accumulator update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_r       <= {WIDTH{1'b0}};
            opb_r       <= {WIDTH{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            acc_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            carry_r     <= 1'b0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
        end else if (accept_s) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with sub.
            opa_r   <= acc_en ? acc_r : a;
            opb_r   <= b ^ {WIDTH{sub}};
            carry_r <= sub;
            cnt_r   <= {CW{1'b0}};
        end else if (state_r == RUN) begin
            sum_r   <= sum_next_s;
            carry_r <= slice_s[DIGIT];
            if (last_s) begin
                cnt_r       <= {CW{1'b0}};
                carry_out_r <= slice_s[DIGIT];
                overflow_r  <= slice_s[DIGIT] ^ c_msb_s;
                zero_r      <= ~|sum_next_s;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else if (release_s) begin
            acc_r <= sum_r;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign carry_out = carry_out_r;
    assign overflow  = overflow_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_addsub_serial.sv
// Testbench for addsub_serial: directed scenarios on WIDTH=8/DIGIT=4, plus
// randomized sweeps on WIDTH=8/DIGIT=8 and WIDTH=16/DIGIT=2. All instances
// are checked against a signed/unsigned arithmetic reference model.
module tb_addsub_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Main instance: WIDTH=8, DIGIT=4.
    logic       m_in_valid = 1'b0, m_in_ready, m_sub = 1'b0, m_acc_en = 1'b0;
    logic       m_out_valid, m_out_ready = 1'b1, m_carry, m_ovf, m_zero;
    logic [7:0] m_a = 8'h00, m_b = 8'h00, m_sum;
    logic [7:0] acc_m = 8'h00;

    // Sweep instance p: WIDTH=8, DIGIT=8.
    logic       p_in_valid = 1'b0, p_in_ready, p_sub = 1'b0, p_acc_en = 1'b0;
    logic       p_out_valid, p_out_ready = 1'b0, p_carry, p_ovf, p_zero;
    logic [7:0] p_a = 8'h00, p_b = 8'h00, p_sum;

    // Sweep instance q: WIDTH=16, DIGIT=2.
    logic        q_in_valid = 1'b0, q_in_ready, q_sub = 1'b0, q_acc_en = 1'b0;
    logic        q_out_valid, q_out_ready = 1'b0, q_carry, q_ovf, q_zero;
    logic [15:0] q_a = 16'h0000, q_b = 16'h0000, q_sum;

    addsub_serial #(.WIDTH(8), .DIGIT(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .a(m_a), .b(m_b), .sub(m_sub), .acc_en(m_acc_en),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .sum(m_sum),
        .carry_out(m_carry), .overflow(m_ovf), .zero(m_zero)
    );

    addsub_serial #(.WIDTH(8), .DIGIT(8)) u_dut_p (
        .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .a(p_a), .b(p_b), .sub(p_sub), .acc_en(p_acc_en),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .sum(p_sum),
        .carry_out(p_carry), .overflow(p_ovf), .zero(p_zero)
    );

    addsub_serial #(.WIDTH(16), .DIGIT(2)) u_dut_q (
        .clk(clk), .rst_n(rst_n), .in_valid(q_in_valid), .in_ready(q_in_ready),
        .a(q_a), .b(q_b), .sub(q_sub), .acc_en(q_acc_en),
        .out_valid(q_out_valid), .out_ready(q_out_ready), .sum(q_sum),
        .carry_out(q_carry), .overflow(q_ovf), .zero(q_zero)
    );

    // Reference model. The sum is the true integer result reduced mod 2^w.
    // Carry means an unsigned result >= 2^w (add) or no borrow, a >= b (sub).
    // Overflow means the exact signed result falls outside the w-bit range.
    function automatic void ref_op(input int w, input longint a, input longint b,
                                   input bit sub, output longint s, output bit c,
                                   output bit ov, output bit z);
        longint lim;
        longint sa;
        longint sb;
        longint res;
        lim = longint'(1) << w;
        sa  = (a >= lim / 2) ? a - lim : a;
        sb  = (b >= lim / 2) ? b - lim : b;
        res = sub ? sa - sb : sa + sb;
        ov  = (res >= lim / 2) || (res < -(lim / 2));
        c   = sub ? (a >= b) : (a + b >= lim);
        s   = sub ? a - b : a + b;
        s   = ((s % lim) + lim) % lim;
        z   = (s == 0);
    endfunction

    // Drive one operation into the main instance and wait for out_valid.
    // lat is the number of clock edges after the accept edge.
    task automatic issue_m(input logic [7:0] a, input logic [7:0] b,
                           input logic sub, input logic acc_en, output int lat);
        @(negedge clk);
        m_a = a; m_b = b; m_sub = sub; m_acc_en = acc_en; m_in_valid = 1'b1;
        @(posedge clk);
        #1;
        m_in_valid = 1'b0;
        m_a = 8'($urandom);
        m_b = 8'($urandom);
        lat = 0;
        while (!m_out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({m_out_valid, m_in_ready, m_sum, m_carry, m_ovf, m_zero} !== {1'b0, 1'b1, 8'h00, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b",
                     {m_out_valid, m_in_ready, m_sum, m_carry, m_ovf, m_zero}, {1'b0, 1'b1, 8'h00, 3'b000});
        end
        rst_n = 1'b1;
    endtask

    // Checks one result on the main instance, then the handshake back to IDLE.
    task automatic check_main(input string name, input logic [7:0] a, input logic [7:0] b,
                              input logic sub, input logic acc_en, input logic [10:0] exp);
        int lat;
        issue_m(a, b, sub, acc_en, lat);
        n_checks++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want 2", name, lat);
        end
        n_checks++;
        if ({m_sum, m_carry, m_ovf, m_zero} !== exp) begin
            n_fail++;
            $display("FAIL %s result {sum,c,ov,z}: got %h,%b want %h,%b", name,
                     m_sum, {m_carry, m_ovf, m_zero}, exp[10:3], exp[2:0]);
        end
        @(posedge clk);
        #1;
        acc_m = exp[10:3];
        n_checks++;
        if ({m_out_valid, m_in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL %s handshake {out_valid,in_ready}: got %b want 01", name,
                     {m_out_valid, m_in_ready});
        end
    endtask

    task automatic test_add();
        check_main("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1, 1'b0});
        check_main("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0, 1'b1});
    endtask

    task automatic test_sub();
        check_main("sub_05_05", 8'h05, 8'h05, 1'b1, 1'b0, {8'h00, 1'b1, 1'b0, 1'b1});
        check_main("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, {8'h7F, 1'b1, 1'b1, 1'b0});
    endtask

    task automatic test_backpressure_acc();
        int lat;
        m_out_ready = 1'b0;
        issue_m(8'h30, 8'h50, 1'b0, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({m_out_valid, m_in_ready, m_sum, m_carry, m_ovf, m_zero} !== {1'b1, 1'b0, 8'h80, 3'b010}) begin
                n_fail++;
                $display("FAIL backpressure_hold cycle %0d: got %b want %b", i,
                         {m_out_valid, m_in_ready, m_sum, m_carry, m_ovf, m_zero}, {1'b1, 1'b0, 8'h80, 3'b010});
            end
            @(posedge clk);
            #1;
        end
        m_out_ready = 1'b1;
        @(posedge clk);
        #1;
        acc_m = 8'h80;
        check_main("acc_sub_10", 8'h00, 8'h10, 1'b1, 1'b1, {8'h70, 1'b1, 1'b1, 1'b0});
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        m_a = 8'h12; m_b = 8'h34; m_sub = 1'b0; m_acc_en = 1'b0; m_in_valid = 1'b1;
        @(posedge clk);
        #1;
        m_in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_out_valid, m_in_ready, m_sum, m_carry, m_ovf, m_zero} !== {1'b0, 1'b1, 8'h00, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_mid_run: got %b want %b",
                     {m_out_valid, m_in_ready, m_sum, m_carry, m_ovf, m_zero}, {1'b0, 1'b1, 8'h00, 3'b000});
        end
        @(negedge clk);
        rst_n = 1'b1;
        acc_m = 8'h00;
        check_main("post_reset_acc", 8'hAA, 8'h03, 1'b0, 1'b1, {8'h03, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       ae;
        longint     s;
        bit         c;
        bit         ov;
        bit         z;
        for (int i = 0; i < 40; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            sub = 1'($urandom);
            ae  = 1'($urandom);
            ref_op(8, longint'(ae ? acc_m : a), longint'(b), sub, s, c, ov, z);
            check_main("b2b", a, b, sub, ae, {8'(s), c, ov, z});
        end
    endtask

    task automatic test_sweep_w8_d8();
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] acc;
        logic       sub;
        logic       ae;
        longint     s;
        bit         c;
        bit         ov;
        bit         z;
        int         lat;
        acc = 8'h00;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); ae = 1'($urandom);
            ref_op(8, longint'(ae ? acc : a), longint'(b), sub, s, c, ov, z);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            p_a = a; p_b = b; p_sub = sub; p_acc_en = ae; p_in_valid = 1'b1;
            @(posedge clk);
            #1;
            p_in_valid = 1'b0;
            lat = 0;
            while (!p_out_valid && lat < 50) begin
                @(posedge clk);
                #1;
                lat++;
            end
            n_checks++;
            if (lat !== 1) begin
                n_fail++;
                $display("FAIL sweep_w8d8 latency op %0d: got %0d want 1", i, lat);
            end
            for (int g = 0; g <= int'($urandom_range(0, 3)); g++) begin
                n_checks++;
                if ({p_out_valid, p_in_ready, p_sum, p_carry, p_ovf, p_zero} !== {1'b1, 1'b0, 8'(s), c, ov, z}) begin
                    n_fail++;
                    $display("FAIL sweep_w8d8 result op %0d: got %b want %b", i,
                             {p_out_valid, p_in_ready, p_sum, p_carry, p_ovf, p_zero}, {1'b1, 1'b0, 8'(s), c, ov, z});
                end
                @(posedge clk);
                #1;
            end
            p_out_ready = 1'b1;
            @(posedge clk);
            #1;
            p_out_ready = 1'b0;
            acc = 8'(s);
        end
    endtask

    task automatic test_sweep_w16_d2();
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] acc;
        logic        sub;
        logic        ae;
        longint      s;
        bit          c;
        bit          ov;
        bit          z;
        int          lat;
        acc = 16'h0000;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); ae = 1'($urandom);
            ref_op(16, longint'(ae ? acc : a), longint'(b), sub, s, c, ov, z);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            q_a = a; q_b = b; q_sub = sub; q_acc_en = ae; q_in_valid = 1'b1;
            @(posedge clk);
            #1;
            q_in_valid = 1'b0;
            lat = 0;
            while (!q_out_valid && lat < 50) begin
                @(posedge clk);
                #1;
                lat++;
            end
            n_checks++;
            if (lat !== 8) begin
                n_fail++;
                $display("FAIL sweep_w16d2 latency op %0d: got %0d want 8", i, lat);
            end
            for (int g = 0; g <= int'($urandom_range(0, 3)); g++) begin
                n_checks++;
                if ({q_out_valid, q_in_ready, q_sum, q_carry, q_ovf, q_zero} !== {1'b1, 1'b0, 16'(s), c, ov, z}) begin
                    n_fail++;
                    $display("FAIL sweep_w16d2 result op %0d: got %b want %b", i,
                             {q_out_valid, q_in_ready, q_sum, q_carry, q_ovf, q_zero}, {1'b1, 1'b0, 16'(s), c, ov, z});
                end
                @(posedge clk);
                #1;
            end
            q_out_ready = 1'b1;
            @(posedge clk);
            #1;
            q_out_ready = 1'b0;
            acc = 16'(s);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure_acc();
        test_reset_mid_run();
        test_back_to_back();
        test_sweep_w8_d8();
        test_sweep_w16_d2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
